coor_scan_ctrl: RTL and testbench
=================================

COOR_SCAN_CTRL -- requirements
Module: coor_scan_ctrl

Interface
REQ-001 Parameter COLS SHALL default to 79; it is the frame row pitch in pixels.
REQ-002 Parameter ROWS SHALL default to 16; it is the number of frame rows.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start SHALL be an input, 1 bit: begin a window scan.
REQ-006 Port abort SHALL be an input, 1 bit: cancel the scan in progress.
REQ-007 Ports x_lo and x_hi SHALL be inputs, 7 bits each: inclusive column bounds.
REQ-008 Ports y_lo and y_hi SHALL be inputs, 4 bits each: inclusive row bounds.
REQ-009 Port mem_ack SHALL be an input, 1 bit: memory accepts the current request.
REQ-010 Port mem_req SHALL be an output, 1 bit: read request to pixel memory.
REQ-011 Port mem_addr SHALL be an output, 11 bits: linear pixel address.
REQ-012 Ports cur_x (7 bits) and cur_y (4 bits) SHALL be outputs giving the coordinate of mem_addr.
REQ-013 Port busy SHALL be an output, 1 bit: scan in progress.
REQ-014 Port done SHALL be an output, 1 bit: one-cycle pulse at scan completion.
REQ-015 Port err SHALL be an output, 1 bit: one-cycle pulse on a rejected start.
REQ-016 Port aborted SHALL be an output, 1 bit: one-cycle pulse on abort.
REQ-017 Port count SHALL be an output, 11 bits: transactions accepted in the current or last scan.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and DONE; busy SHALL be 1 exactly in REQ.
REQ-019 In IDLE, a start with x_lo<=x_hi<COLS and y_lo<=y_hi<ROWS SHALL latch the bounds, set cur_x=x_lo, cur_y=y_lo, clear count, and enter REQ on the next edge.
REQ-020 In IDLE, a start with an invalid window SHALL pulse err for one cycle and remain in IDLE.
REQ-021 start SHALL be ignored outside IDLE; bound inputs SHALL be sampled only on an accepted start.
REQ-022 mem_addr SHALL equal cur_y*COLS+cur_x at all times in REQ, computed with no truncation in 11 bits.
REQ-023 In REQ, mem_req SHALL be 1; mem_addr, cur_x and cur_y SHALL be held stable until mem_ack is sampled 1.
REQ-024 mem_ack high in the same cycle as mem_req SHALL complete the transaction; back-to-back accepts SHALL sustain one address per cycle.
REQ-025 On each accept, count SHALL increment by 1; coordinates SHALL advance in raster order: cur_x+1, or when cur_x=x_hi, cur_x=x_lo and cur_y+1.
REQ-026 An accept at (x_hi, y_hi) SHALL move the FSM to DONE; DONE SHALL pulse done, drop mem_req, and return to IDLE on the next edge.
REQ-027 Latency SHALL be: start accepted at edge N gives mem_req=1 with the first address after edge N; the last accept at edge M gives done=1 after edge M.
REQ-028 abort in REQ SHALL have priority over advancing: the FSM returns to IDLE, aborted pulses, done is not asserted; a mem_ack in that same cycle SHALL still be counted.
REQ-029 abort in IDLE or DONE SHALL be ignored.
REQ-030 mem_ack outside REQ SHALL be ignored.
REQ-031 count SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE with mem_req, busy, done, err and aborted at 0, and cur_x, cur_y, mem_addr and count at 0.
REQ-033 Reset asserted mid-scan SHALL abandon the scan immediately, with no done or aborted pulse.

Verification
REQ-034 Window x 0..1, y 0..1 with mem_ack tied 1 -> mem_addr 0,1,79,80 on four consecutive cycles; done one cycle later; count=4.
REQ-035 Full frame x 0..78, y 0..15 with ack tied 1 -> 1264 accepts; last mem_addr=1263; done pulses once.
REQ-036 Window x 5..6, y 2..2 with ack asserted only every third cycle -> mem_addr 163 held for 3 cycles, then 164; count=2.
REQ-037 Start with x_lo=5, x_hi=4, and separately with x_hi=79 -> err pulse, busy stays 0, mem_req stays 0.
REQ-038 Abort on the second request of window x 0..3, y 0..0 with ack tied 1 -> aborted pulse, count=2, no done; reset asserted mid-scan -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/coor_scan_ctrl.sv
// Window scan controller: walks a rectangular pixel window in raster order and
// issues one linear-address memory read request per coordinate, with req/ack handshake.
module coor_scan_ctrl #(
  parameter int COLS = 79,
  parameter int ROWS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [6:0]  x_lo,
  input  logic [6:0]  x_hi,
  input  logic [3:0]  y_lo,
  input  logic [3:0]  y_hi,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [10:0] mem_addr,
  output logic [6:0]  cur_x,
  output logic [3:0]  cur_y,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted,
  output logic [10:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [6:0]  X_MAX  = 7'(COLS - 1);
  localparam logic [3:0]  Y_MAX  = 4'(ROWS - 1);
  localparam logic [10:0] COLS_W = 11'(COLS);

  state_t      r_state, w_next;
  logic [6:0]  r_x_lo, r_x_hi, r_cur_x;
  logic [3:0]  r_y_hi, r_cur_y;
  logic [10:0] r_count;
  logic        r_err, r_aborted;

  logic w_valid, w_accept, w_last_x, w_last;

  assign w_valid  = (x_lo <= x_hi) && (x_hi <= X_MAX) && (y_lo <= y_hi) && (y_hi <= Y_MAX);
  assign w_accept = (r_state == S_REQ) && mem_ack;
  assign w_last_x = (r_cur_x == r_x_hi);
  assign w_last   = w_last_x && (r_cur_y == r_y_hi);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && w_valid) w_next = S_REQ;
      S_REQ: begin
        if (abort)                 w_next = S_IDLE;
        else if (w_accept && w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_lo    <= '0;
      r_x_hi    <= '0;
      r_y_hi    <= '0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
      if (r_state == S_IDLE && start) begin
        if (w_valid) begin
          r_x_lo  <= x_lo;
          r_x_hi  <= x_hi;
          r_y_hi  <= y_hi;
          r_cur_x <= x_lo;
          r_cur_y <= y_lo;
          r_count <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_REQ) begin
        r_aborted <= abort;
        if (mem_ack) begin
          r_count <= r_count + 11'd1;
          // Coordinates freeze on the final pixel so they never leave the window.
          if (!abort && !w_last) begin
            if (w_last_x) begin
              r_cur_x <= r_x_lo;
              r_cur_y <= r_cur_y + 4'd1;
            end else begin
              r_cur_x <= r_cur_x + 7'd1;
            end
          end
        end
      end
    end
  end

  assign mem_req  = (r_state == S_REQ);
  assign busy     = (r_state == S_REQ);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign aborted  = r_aborted;
  assign cur_x    = r_cur_x;
  assign cur_y    = r_cur_y;
  assign count    = r_count;
  assign mem_addr = 11'(r_cur_y) * COLS_W + 11'(r_cur_x);

endmodule

// File: tb/tb_coor_scan_ctrl.sv
// Directed bench for coor_scan_ctrl: expected coordinates/addresses are queued
// when a scan is launched and popped as the DUT's requests are accepted.
module tb_coor_scan_ctrl;
  localparam int COLS = 79;
  localparam int ROWS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mem_ack = 1'b0;
  logic [6:0]  x_lo = '0, x_hi = '0;
  logic [3:0]  y_lo = '0, y_hi = '0;
  logic        mem_req, busy, done, err, aborted;
  logic [10:0] mem_addr, count;
  logic [6:0]  cur_x;
  logic [3:0]  cur_y;

  coor_scan_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_lo(x_lo), .x_hi(x_hi), .y_lo(y_lo), .y_hi(y_hi),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .done(done),
    .err(err), .aborted(aborted), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Launches a scan and services it; ack on every ack_period-th cycle a request
  // is held, abort asserted while request number abort_at is presented (-1: never).
  task automatic scan(input int xl, input int xh, input int yl, input int yh,
                      input int ack_period, input int abort_at,
                      output int acc, output int dones, output int aborts);
    int   phase = 0;
    int   cyc = 0;
    int   last_acc = -1;
    int   done_cyc = -1;
    int   tail = -1;
    exp_t e;
    acc = 0; dones = 0; aborts = 0;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        e.addr = y * COLS + x; e.x = x; e.y = y;
        sb.push_back(e);
      end
    @(negedge clk);
    start = 1'b1;
    x_lo = xl[6:0]; x_hi = xh[6:0]; y_lo = yl[3:0]; y_hi = yh[3:0];
    @(negedge clk);
    start = 1'b0;
    x_lo = 7'($urandom); x_hi = 7'($urandom); y_lo = 4'($urandom); y_hi = 4'($urandom);
    check("first_req", {31'd0, mem_req}, 32'd1);
    while (tail != 0 && cyc < 3000) begin
      if (done)    begin dones++; done_cyc = cyc; end
      if (aborted) aborts++;
      mem_ack = 1'b0;
      abort   = 1'b0;
      if (tail >= 0) begin
        check("req_dropped", {31'd0, mem_req}, 32'd0);
        tail--;
      end else if (!mem_req) begin
        check("req_held", {31'd0, mem_req}, 32'd1);
        tail = 2;
      end else begin
        check("mem_addr", 32'(mem_addr), sb[0].addr);
        check("cur_x", 32'(cur_x), sb[0].x);
        check("cur_y", 32'(cur_y), sb[0].y);
        check("busy", {31'd0, busy}, 32'd1);
        mem_ack = (phase % ack_period) == (ack_period - 1);
        abort   = (acc == abort_at);
        if (mem_ack) begin
          void'(sb.pop_front());
          acc++;
          last_acc = cyc;
          phase = 0;
        end else begin
          phase++;
        end
        if ((mem_ack && sb.size() == 0) || abort) tail = 2;
      end
      cyc++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    abort   = 1'b0;
    check("scan_terminated", tail, 0);
    if (abort_at < 0) begin
      check("sb_drained", sb.size(), 0);
      check("done_latency", done_cyc - last_acc, 1);
    end
    sb.delete();
  endtask

  task automatic bad_start(input string tag, input int xl, input int xh);
    @(negedge clk);
    start = 1'b1; x_lo = xl[6:0]; x_hi = xh[6:0]; y_lo = 4'd0; y_hi = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err"},  {31'd0, err},     32'd1);
    check({tag, "_busy"}, {31'd0, busy},    32'd0);
    check({tag, "_req"},  {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check({tag, "_err_pulse"}, {31'd0, err},  32'd0);
    check({tag, "_busy2"},     {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int acc, dones, aborts;

    #2;
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_busy",  {31'd0, busy},    32'd0);
    check("rst_addr",  32'(mem_addr),    32'd0);
    check("rst_count", 32'(count),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2x2 window, ack always
    scan(0, 1, 0, 1, 1, -1, acc, dones, aborts);
    check("w2x2_acc",   acc,         4);
    check("w2x2_done",  dones,       1);
    check("w2x2_count", 32'(count),  32'd4);

    // count holds in IDLE; stray ack/abort ignored
    @(negedge clk);
    mem_ack = 1'b1; abort = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; abort = 1'b0;
    check("idle_count_hold", 32'(count),   32'd4);
    check("idle_no_abort",   {31'd0, aborted}, 32'd0);
    check("idle_no_req",     {31'd0, mem_req}, 32'd0);

    // full frame
    scan(0, COLS - 1, 0, ROWS - 1, 1, -1, acc, dones, aborts);
    check("full_acc",   acc,        COLS * ROWS);
    check("full_done",  dones,      1);
    check("full_count", 32'(count), 32'(COLS * ROWS));

    // slow ack: every third cycle
    scan(5, 6, 2, 2, 3, -1, acc, dones, aborts);
    check("slow_acc",   acc,        2);
    check("slow_count", 32'(count), 32'd2);

    // invalid windows
    bad_start("x_inverted", 5, 4);
    bad_start("x_too_big",  0, 79);

    // abort on the second request
    scan(0, 3, 0, 0, 1, 1, acc, dones, aborts);
    check("abort_pulse", aborts,     1);
    check("abort_nodone", dones,     0);
    check("abort_count", 32'(count), 32'd2);

    // reset mid-scan
    @(negedge clk);
    start = 1'b1; x_lo = 7'd2; x_hi = 7'd5; y_lo = 4'd1; y_hi = 4'd3;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_addr", 32'(mem_addr), 32'(1 * COLS + 2));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("pre_rst_count", 32'(count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",     {31'd0, mem_req}, 32'd0);
    check("arst_busy",    {31'd0, busy},    32'd0);
    check("arst_done",    {31'd0, done},    32'd0);
    check("arst_aborted", {31'd0, aborted}, 32'd0);
    check("arst_err",     {31'd0, err},     32'd0);
    check("arst_cur_x",   32'(cur_x),       32'd0);
    check("arst_cur_y",   32'(cur_y),       32'd0);
    check("arst_addr",    32'(mem_addr),    32'd0);
    check("arst_count",   32'(count),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy",    {31'd0, busy},    32'd0);
    check("post_rst_done",    {31'd0, done},    32'd0);
    check("post_rst_aborted", {31'd0, aborted}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
